// File: rtl/div_iter_if.sv
// div_iter_if: request/response bundle between the pipeline and the iterative divider.
interface div_iter_if #(parameter int WIDTH = 32);
    logic               start;
    logic               annul;
    logic               signed_div;
    logic [WIDTH-1:0]   opdata1;
    logic [WIDTH-1:0]   opdata2;
    logic [2*WIDTH-1:0] result;
    logic               ready;
    logic               busy;
    logic               div_by_zero;
    modport master (
        output start, annul, signed_div, opdata1, opdata2,
        input  result, ready, busy, div_by_zero
    );
    modport slave (
        input  start, annul, signed_div, opdata1, opdata2,
        output result, ready, busy, div_by_zero
    );
endinterface

// File: rtl/div_iter.sv
// div_iter: restoring radix-2 divider, one quotient bit per cycle, result = {remainder, quotient}.
module div_iter #(parameter int WIDTH = 32) (
    input logic       clk,
    input logic       rst,
    div_iter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t           state;
    logic [CW-1:0]    cnt;
    logic             neg_q, neg_r;
    logic [WIDTH-1:0] q, r, d;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] q_n, r_n, q_fix, r_fix;
    always_comb begin
        a_neg   = bus.signed_div & bus.opdata1[WIDTH-1];
        b_neg   = bus.signed_div & bus.opdata2[WIDTH-1];
        a_mag   = a_neg ? -bus.opdata1 : bus.opdata1;
        b_mag   = b_neg ? -bus.opdata2 : bus.opdata2;
        shifted = {r, q[WIDTH-1]};
        diff    = shifted - {1'b0, d};
        // a borrow out of the trial subtract means the divisor did not fit
        q_n     = {q[WIDTH-2:0], ~diff[WIDTH]};
        r_n     = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        q_fix   = neg_q ? -q_n : q_n;
        r_fix   = neg_r ? -r_n : r_n;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            q               <= '0;
            r               <= '0;
            d               <= '0;
            bus.result      <= '0;
            bus.ready       <= 1'b0;
            bus.busy        <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start && !bus.annul) begin
                    bus.busy <= 1'b1;
                    if (bus.opdata2 != '0) begin
                        state <= ON;
                        q     <= a_mag;
                        r     <= '0;
                        d     <= b_mag;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        cnt   <= '0;
                    end else begin
                        state <= DIVZERO;
                        r     <= bus.opdata1;
                    end
                end
                DIVZERO: begin
                    bus.busy <= 1'b0;
                    if (bus.annul) state <= IDLE;
                    else begin
                        state           <= END;
                        bus.ready       <= 1'b1;
                        bus.result      <= {r, {WIDTH{1'b1}}};
                        bus.div_by_zero <= 1'b1;
                    end
                end
                ON: if (bus.annul) begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end else begin
                    q   <= q_n;
                    r   <= r_n;
                    cnt <= (cnt == LAST) ? cnt : cnt + 1'b1;
                    if (cnt == LAST) begin
                        state           <= END;
                        bus.busy        <= 1'b0;
                        bus.ready       <= 1'b1;
                        bus.result      <= {r_fix, q_fix};
                        bus.div_by_zero <= 1'b0;
                    end
                end
                END: if (!bus.start || bus.annul) begin
                    state     <= IDLE;
                    bus.ready <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed vector table plus annul/reset sequences for div_iter at WIDTH=32.
module tb_div_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;
    always #5 clk = ~clk;
    div_iter_if #(.WIDTH(32)) bus ();
    div_iter #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        logic        sd;
        logic [31:0] a, b, q, r;
        logic        dbz;
        int          lat;
    } vec_t;
    vec_t v[13];
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else passed++;
    endtask
    task automatic run_div(input vec_t t, input string nm);
        int   n;
        logic busy_ok;
        @(negedge clk);
        bus.start = 1'b1; bus.signed_div = t.sd; bus.opdata1 = t.a; bus.opdata2 = t.b;
        busy_ok = 1'b1;
        @(posedge clk); n = 1;
        @(negedge clk);
        // operands and mode are scrambled after acceptance and must not matter
        bus.signed_div = ~t.sd; bus.opdata1 = $urandom; bus.opdata2 = $urandom;
        while (!bus.ready && n < 40) begin
            if (!bus.busy) busy_ok = 1'b0;
            @(posedge clk); n++;
            @(negedge clk);
        end
        chk({nm, " latency"}, 64'(n), 64'(t.lat));
        chk({nm, " result"}, bus.result, {t.r, t.q});
        chk({nm, " div_by_zero"}, 64'(bus.div_by_zero), 64'(t.dbz));
        chk({nm, " busy during"}, 64'(busy_ok), 64'(1));
        chk({nm, " busy at end"}, 64'(bus.busy), 64'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk({nm, " ready held"}, 64'(bus.ready), 64'(1));
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({nm, " ready drop"}, 64'(bus.ready), 64'(0));
    endtask
    initial begin
        logic        seen;
        logic [63:0] prior;
        v[0]  = '{1'b0, 32'd100,        32'd7,          32'h0000000E, 32'h00000002, 1'b0, 33};
        v[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33};
        v[2]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC, 32'h00000001, 1'b0, 33};
        v[3]  = '{1'b0, 32'd5,          32'd0,          32'hFFFFFFFF, 32'h00000005, 1'b1, 2};
        v[4]  = '{1'b0, 32'd9,          32'd3,          32'h00000003, 32'h00000000, 1'b0, 33};
        v[5]  = '{1'b1, 32'd5,          32'd0,          32'hFFFFFFFF, 32'h00000005, 1'b1, 2};
        v[6]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000, 1'b0, 33};
        v[7]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD, 32'h00000001, 1'b0, 33};
        v[8]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'h0000000E, 32'hFFFFFFFE, 1'b0, 33};
        v[9]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF, 32'h00000000, 1'b0, 33};
        v[10] = '{1'b0, 32'd3,          32'd10,         32'h00000000, 32'h00000003, 1'b0, 33};
        v[11] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h00000000, 32'h80000000, 1'b0, 33};
        v[12] = '{1'b1, 32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 2};
        bus.start = 1'b0; bus.annul = 1'b0; bus.signed_div = 1'b0;
        bus.opdata1 = '0; bus.opdata2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset result", bus.result, 64'h0);
        chk("reset ready", 64'(bus.ready), 64'(0));
        chk("reset busy", 64'(bus.busy), 64'(0));
        chk("reset dbz", 64'(bus.div_by_zero), 64'(0));
        rst = 1'b0;
        for (int i = 0; i < 13; i++) run_div(v[i], $sformatf("v%0d", i));
        // annul in ON at edge 10: result and flag must survive
        prior = bus.result;
        @(negedge clk);
        bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd1000; bus.opdata2 = 32'd3;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("annul busy before", 64'(bus.busy), 64'(1));
        bus.annul = 1'b1; bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.annul = 1'b0;
        chk("annul busy", 64'(bus.busy), 64'(0));
        seen = 1'b0;
        repeat (40) begin @(negedge clk); seen |= bus.ready; end
        chk("annul no ready", 64'(seen), 64'(0));
        chk("annul result kept", bus.result, prior);
        chk("annul dbz kept", 64'(bus.div_by_zero), 64'(1));
        run_div(v[4], "after annul");
        // annul in DIVZERO
        prior = bus.result;
        @(negedge clk);
        bus.start = 1'b1; bus.opdata1 = 32'd5; bus.opdata2 = 32'd0;
        @(posedge clk);
        @(negedge clk);
        chk("dz annul busy before", 64'(bus.busy), 64'(1));
        bus.annul = 1'b1; bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.annul = 1'b0;
        seen = bus.ready;
        repeat (5) begin @(negedge clk); seen |= bus.ready; end
        chk("dz annul busy", 64'(bus.busy), 64'(0));
        chk("dz annul no ready", 64'(seen), 64'(0));
        chk("dz annul dbz kept", 64'(bus.div_by_zero), 64'(0));
        chk("dz annul result kept", bus.result, prior);
        // asynchronous reset mid-division, after a zero-divisor completion
        run_div(v[3], "pre reset");
        @(negedge clk);
        bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd77; bus.opdata2 = 32'd5;
        repeat (15) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst result", bus.result, 64'h0);
        chk("async rst ready", 64'(bus.ready), 64'(0));
        chk("async rst busy", 64'(bus.busy), 64'(0));
        chk("async rst dbz", 64'(bus.div_by_zero), 64'(0));
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_div(v[0], "after reset");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
